// File: rtl/ym6045c_sr_par.sv
// ym6045c_sr_par: WIDTH-bit shift register with parallel load, selectable
// shift direction, shift-count tracker and a handshaked holding register.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   res_n_i      synchronous active-low reset
//   en_i         shift enable
//   load_i       parallel load strobe (wins over en_i)
//   dir_i        0 = shift right (sin enters MSB), 1 = shift left (sin enters LSB)
//   sin_i        serial data in
//   pdin_i       parallel load data
//   hold_ack_i   consumer acknowledge of the holding register
//   q_o          shift register contents
//   sout_o       bit next to leave, combinational from q and dir
//   cnt_o        shifts since last load, reset or word boundary
//   word_done_o  one-cycle pulse in the cycle q first shows a completed word
//   hold_o       last completed word
//   hold_valid_o hold_o contains an unacknowledged word
//   overrun_o    sticky: a word completed over an unacknowledged one
module ym6045c_sr_par #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             res_n_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             dir_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] pdin_i,
    input  logic             hold_ack_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             word_done_o,
    output logic [WIDTH-1:0] hold_o,
    output logic             hold_valid_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        q_d          = q_q;
        cnt_d        = cnt_q;
        word_done_d  = 1'b0;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;
        complete     = 1'b0;

        shifted = dir_i ? {q_q[WIDTH-2:0], sin_i}
                        : {sin_i, q_q[WIDTH-1:1]};

        if (load_i) begin
            q_d   = pdin_i;
            cnt_d = '0;
        end else if (en_i) begin
            q_d = shifted;
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                word_done_d = 1'b1;
                complete    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A completing word always leaves hold_valid set; a same-cycle
        // ack only suppresses the overrun flag.
        if (complete) begin
            hold_d       = shifted;
            hold_valid_d = 1'b1;
            if (hold_valid_q && !hold_ack_i) begin
                overrun_d = 1'b1;
            end
        end else if (hold_ack_i) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            q_q          <= RESET_VAL;
            cnt_q        <= '0;
            word_done_q  <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            word_done_q  <= word_done_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign q_o          = q_q;
    assign sout_o       = dir_i ? q_q[WIDTH-1] : q_q[0];
    assign cnt_o        = cnt_q;
    assign word_done_o  = word_done_q;
    assign hold_o       = hold_q;
    assign hold_valid_o = hold_valid_q;
    assign overrun_o    = overrun_q;

endmodule
